farbborg_scan: RTL and testbench

Display-side reader for the farbborg frame buffer. It walks the 32-bit read port of the frame dual-port RAM row by row and converts each brightness byte into one on/off bit per PWM level. It shifts those bits into the LED column drivers, latches them, and multiplexes the row select. The CPU writes bytes through the RAM's write port; this block is the only consumer of the read port.

---
 rtl/farbborg_scan.sv | 150 +++++++++++++++
 tb/tb_farbborg_scan.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/farbborg_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// farbborg_scan : frame RAM reader, 15-slot PWM slicer, column shift/latch and
//                 row multiplexer for the farbborg LED matrix.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module farbborg_scan #(
  parameter int ROWS  = 16,
  parameter int WORDS = 8,
  parameter int HOLD  = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [8:0]  addr_o,
  input  logic [31:0] data_i,
  output logic        sdo_o,
  output logic        sclk_o,
  output logic        latch_o,
  output logic        oe_n_o,
  output logic [5:0]  row_o,
  output logic        frame_o
);

  localparam int         WW         = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int         HW         = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [3:0] LAST_LEVEL = 4'd14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FRAME = 3'd1,
    FETCH = 3'd2,
    CAPT  = 3'd3,
    SHIFT = 3'd4,
    LATCH = 3'd5,
    SHOW  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    row_q, row_d;
  logic [5:0]    row_out_q, row_out_d;
  logic [WW-1:0] word_q, word_d;
  logic [3:0]    level_q, level_d;
  logic [3:0]    shreg_q, shreg_d;
  logic [2:0]    bit_q, bit_d;
  logic [HW-1:0] hold_q, hold_d;

  // Low nibbles carry no brightness information at 15 PWM slots.
  logic w_unused;
  assign w_unused = ^{data_i[27:24], data_i[19:16], data_i[11:8], data_i[3:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      row_q     <= '0;
      row_out_q <= '0;
      word_q    <= '0;
      level_q   <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      row_out_q <= row_out_d;
      word_q    <= word_d;
      level_q   <= level_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    row_out_d = row_out_q;
    word_d    = word_q;
    level_d   = level_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = FRAME;
      end
      FRAME: begin
        row_d   = '0;
        word_d  = '0;
        level_d = '0;
        state_d = FETCH;
      end
      FETCH: state_d = CAPT;
      CAPT: begin
        shreg_d = {data_i[31:28] > level_q, data_i[23:20] > level_q,
                   data_i[15:12] > level_q, data_i[7:4] > level_q};
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bit_d = bit_q + 3'd1;
        // Even cycle presents the bit, odd cycle raises sclk; advance after the rise.
        if (bit_q[0] && bit_q != 3'd7) shreg_d = {shreg_q[2:0], 1'b0};
        if (bit_q == 3'd7) begin
          if (word_q == WW'(WORDS - 1)) begin
            word_d    = '0;
            row_out_d = row_q;
            state_d   = LATCH;
          end else begin
            word_d  = word_q + WW'(1);
            state_d = FETCH;
          end
        end
      end
      LATCH: begin
        hold_d  = '0;
        state_d = SHOW;
      end
      SHOW: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(HOLD - 1)) begin
          if (level_q != LAST_LEVEL) begin
            level_d = level_q + 4'd1;
            state_d = FETCH;
          end else begin
            level_d = '0;
            if (row_q == 6'(ROWS - 1)) begin
              row_d   = '0;
              state_d = en_i ? FRAME : IDLE;
            end else begin
              row_d   = row_q + 6'd1;
              state_d = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_o  = 9'(row_q) * 9'(WORDS) + 9'(word_q);
  assign sdo_o   = shreg_q[3];
  assign sclk_o  = (state_q == SHIFT) && bit_q[0];
  assign latch_o = (state_q == LATCH);
  assign oe_n_o  = (state_q != SHOW);
  assign row_o   = row_out_q;
  assign frame_o = (state_q == FRAME);

endmodule
`default_nettype wire

// File: tb/tb_farbborg_scan.sv
`default_nettype none
// Scoreboard bench for farbborg_scan: expected latch records are queued by the
// stimulus process and checked by an independent monitor on every latch_o.
module tb_farbborg_scan;

  localparam int ROWS = 16, WORDS = 8, HOLD = 64, PERIOD = 145;

  logic        clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0;
  logic [8:0]  addr_o;
  logic [31:0] data_i = '0;
  logic        sdo_o, sclk_o, latch_o, oe_n_o, frame_o;
  logic [5:0]  row_o;

  farbborg_scan #(.ROWS(ROWS), .WORDS(WORDS), .HOLD(HOLD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .addr_o(addr_o), .data_i(data_i),
    .sdo_o(sdo_o), .sclk_o(sclk_o), .latch_o(latch_o), .oe_n_o(oe_n_o),
    .row_o(row_o), .frame_o(frame_o));

  always #5 clk_i = ~clk_i;

  logic [31:0] ram [0:511];
  always @(posedge clk_i) data_i <= ram[addr_o];

  typedef struct packed {
    logic [5:0]  row;
    logic [31:0] bits;
    logic [71:0] addrs;
  } exp_t;
  exp_t q[$];

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // First four bits of row 0 (word 0x804020F0) and bits of row 1 word 2 (0x0F1E3C5A) per level.
  logic [3:0] T_R0W0 [0:14] = '{4'hF, 4'hF, 4'hD, 4'hD, 4'h9, 4'h9, 4'h9, 4'h9,
                                4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
  logic [3:0] T_R1W2 [0:14] = '{4'h7, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  task automatic push_level(input int r, input int l);
    exp_t e;
    e.row   = 6'(r);
    e.bits  = 32'hFFFF_FFFF;
    e.addrs = '0;
    if (r == 0) e.bits[31:28] = T_R0W0[l];
    if (r == 1) e.bits[23:20] = T_R1W2[l];
    for (int w = 0; w < WORDS; w++) e.addrs = {e.addrs[62:0], 9'(r * WORDS + w)};
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0, latches = 0, frames = 0, rises = 0;
  int          nrise, oe_run, last_latch, frame_cyc;
  logic        prev_sclk, prev_sdo, bad, frame_since, want_first;
  logic [31:0] col;
  logic [71:0] fa;
  logic [8:0]  h1, h2, h3;

  initial begin
    exp_t e;
    nrise = 0; oe_run = 0; last_latch = -1; frame_cyc = 0;
    prev_sclk = 0; prev_sdo = 0; bad = 0; frame_since = 0; want_first = 0;
    col = '0; fa = '0; h1 = '0; h2 = '0; h3 = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        nrise = 0; oe_run = 0; last_latch = -1; prev_sclk = 0; prev_sdo = 0;
        bad = 0; frame_since = 0; want_first = 0; col = '0; fa = '0;
        h1 = '0; h2 = '0; h3 = '0;
      end else begin
        if (sclk_o && !prev_sclk) begin
          rises++;
          if (nrise % 4 == 0) begin
            fa = {fa[62:0], h3};
            if (want_first) begin
              check("frame_to_fetch", cyc - 3 - frame_cyc, 1);
              check("first_fetch_addr", h3, 0);
              want_first = 0;
            end
          end
          if (sdo_o !== prev_sdo) bad = 1;
          if (oe_n_o !== 1'b1) bad = 1;
          col = {col[30:0], sdo_o};
          nrise++;
        end
        if (latch_o) begin
          latches++;
          if (oe_n_o !== 1'b1) bad = 1;
          check("exp_available", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("latch_row", row_o, e.row);
            check("latch_bits", col, e.bits);
            check("fetch_addrs", fa, e.addrs);
            check("rises_per_level", nrise, 32);
            check("shift_timing", bad, 0);
          end
          if (last_latch >= 0 && !frame_since) check("latch_period", cyc - last_latch, PERIOD);
          last_latch = cyc; frame_since = 0; nrise = 0; bad = 0;
        end
        if (frame_o) begin
          frames++; frame_cyc = cyc; frame_since = 1; want_first = 1;
        end
        if (oe_n_o === 1'b0) oe_run++;
        else if (oe_run > 0) begin
          check("oe_low_run", oe_run, HOLD);
          oe_run = 0;
        end
        prev_sclk = sclk_o; prev_sdo = sdo_o;
        h3 = h2; h2 = h1; h1 = addr_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [19:0] outs();
    return {addr_o, sdo_o, sclk_o, latch_o, oe_n_o, row_o, frame_o};
  endfunction
  localparam logic [19:0] RST_OUTS = {9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};

  initial begin
    int n, nbad, r0, f0, l0;
    for (int i = 0; i < 512; i++) ram[i] = 32'hFFFF_FFFF;
    ram[0]  = 32'h8040_20F0;
    ram[10] = 32'h0F1E_3C5A;

    repeat (3) @(negedge clk_i);
    check("reset_outputs", outs(), RST_OUTS);
    rst_ni = 1'b1;
    nbad = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (outs() !== RST_OUTS) nbad++;
    end
    check("idle_outputs", nbad, 0);
    check("idle_rises", rises, 0);
    check("idle_frames", frames, 0);

    // Frame 1 with enable dropped at row 5.
    for (int r = 0; r < ROWS; r++) for (int l = 0; l < 15; l++) push_level(r, l);
    en_i = 1'b1;
    n = 0;
    while (row_o !== 6'd5 && n < 20000) begin @(negedge clk_i); n++; end
    check("reach_row5", n < 20000, 1);
    en_i = 1'b0;
    n = 0;
    while (latches < 240 && n < 40000) begin @(negedge clk_i); n++; end
    check("frame1_latches", n < 40000, 1);
    n = 0;
    while (oe_n_o !== 1'b0 && n < 10) begin @(negedge clk_i); n++; end
    while (oe_n_o !== 1'b1 && n < 200) begin @(negedge clk_i); n++; end
    check("last_show_end", n < 200, 1);
    r0 = rises; f0 = frames; l0 = latches; nbad = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (oe_n_o !== 1'b1) nbad++;
    end
    check("idle_after_drop_oe", nbad, 0);
    check("idle_after_drop_rises", rises - r0, 0);
    check("idle_after_drop_latches", latches - l0, 0);
    check("frames_after_frame1", f0, 1);
    check("frame1_queue_empty", q.size(), 0);

    // Frame 2, interrupted by reset during the shift of row 7.
    for (int r = 0; r < 7; r++) for (int l = 0; l < 15; l++) push_level(r, l);
    en_i = 1'b1;
    n = 0;
    while (latches < 345 && n < 20000) begin @(negedge clk_i); n++; end
    check("frame2_rows0_6", n < 20000, 1);
    n = 0;
    while (oe_n_o !== 1'b0 && n < 10) begin @(negedge clk_i); n++; end
    while (oe_n_o !== 1'b1 && n < 200) begin @(negedge clk_i); n++; end
    r0 = rises;
    while (rises - r0 < 6 && n < 400) begin @(negedge clk_i); n++; end
    check("row7_shifting", n < 400, 1);
    check("frames_before_reset", frames, 2);
    #1 rst_ni = 1'b0;
    #1 check("async_reset_outputs", outs(), RST_OUTS);
    repeat (3) @(negedge clk_i);
    check("held_reset_outputs", outs(), RST_OUTS);
    q.delete();
    push_level(0, 0);
    rst_ni = 1'b1;
    n = 0;
    while (latches < 346 && n < 400) begin @(negedge clk_i); n++; end
    check("restart_latch", n < 400, 1);
    check("frames_after_restart", frames, 3);
    check("final_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
